// File: rtl/shift_pkg.sv
// Shared types and widths for the shift arbiter and its barrel shifter.
package shift_pkg;

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned XLEN    = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter producing all three shift flavours in parallel.
module shift_arbiter_shifter
    import shift_pkg::*;
(
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [XLEN-1:0]    o_sll,
    output logic [XLEN-1:0]    o_srl,
    output logic [XLEN-1:0]    o_sra
);

    assign o_sll = i_data << i_shamt;
    assign o_srl = i_data >> i_shamt;
    assign o_sra = XLEN'($signed(i_data) >>> i_shamt);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ requesters, 1-cycle registered response.
// Optional per-requester grant counters are built when SHIFT_ARB_PERF_EN is defined.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*XLEN-1:0]    i_req_data,
    input  logic [NUM_REQ*SHAMT_W-1:0] i_req_shamt,
    input  logic [NUM_REQ*2-1:0]       i_req_op,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [XLEN-1:0]            o_rsp_data,
    output logic [IDW-1:0]             o_rsp_id,
    output logic [NUM_REQ*CNT_W-1:0]   o_grant_cnt
);

    logic [NUM_REQ-1:0][XLEN-1:0]    req_data;
    logic [NUM_REQ-1:0][SHAMT_W-1:0] req_shamt;
    logic [NUM_REQ-1:0][1:0]         req_op;

    slot_state_e     slot_q;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx;
    logic [IDW-1:0]  rr_next;
    logic [IDW:0]    scan_sum;
    logic            found;
    logic            can_accept;
    logic            grant;
    logic [XLEN-1:0] sll_res;
    logic [XLEN-1:0] srl_res;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] shift_res;

    assign req_data  = i_req_data;
    assign req_shamt = i_req_shamt;
    assign req_op    = i_req_op;

    assign o_rsp_valid = (slot_q == SLOT_FULL);
    assign can_accept  = !o_rsp_valid || i_rsp_ready;
    assign grant       = found && can_accept;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!found && i_req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    assign rr_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);

    shift_arbiter_shifter u_shifter (
        .i_data  (req_data[grant_idx]),
        .i_shamt (req_shamt[grant_idx]),
        .o_sll   (sll_res),
        .o_srl   (srl_res),
        .o_sra   (sra_res)
    );

    always_comb begin
        shift_res = req_data[grant_idx];
        case (shift_op_e'(req_op[grant_idx]))
            SHIFT_SLL:  shift_res = sll_res;
            SHIFT_SRL:  shift_res = srl_res;
            SHIFT_SRA:  shift_res = sra_res;
            SHIFT_PASS: shift_res = req_data[grant_idx];
            default:    shift_res = req_data[grant_idx];
        endcase
    end

    // Output slot: a grant always (re)fills it; it empties only when drained with no new grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_q     <= SLOT_EMPTY;
            o_rsp_data <= '0;
            o_rsp_id   <= '0;
            rr_ptr     <= '0;
        end else begin
            case (slot_q)
                SLOT_EMPTY: if (grant) slot_q <= SLOT_FULL;
                SLOT_FULL:  if (i_rsp_ready && !grant) slot_q <= SLOT_EMPTY;
                default:    slot_q <= SLOT_EMPTY;
            endcase
            if (grant) begin
                o_rsp_data <= shift_res;
                o_rsp_id   <= grant_idx;
                rr_ptr     <= rr_next;
            end
        end
    end

`ifdef SHIFT_ARB_PERF_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt;

    // Saturating count of accepted requests per requester.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_cnt <= '0;
        end else if (grant && (grant_cnt[grant_idx] != {CNT_W{1'b1}})) begin
            grant_cnt[grant_idx] <= grant_cnt[grant_idx] + CNT_W'(1);
        end
    end

    assign o_grant_cnt = grant_cnt;
`else
    assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (NUM_REQ=2, CNT_W=2); honours SHIFT_ARB_PERF_EN.
module tb_shift_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned IDW     = 1;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_data;
    logic [NUM_REQ*5-1:0]   req_shamt;
    logic [NUM_REQ*2-1:0]   req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic [NUM_REQ*CNT_W-1:0] grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt[NUM_REQ];

    shift_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .i_req_shamt (req_shamt),
        .i_req_op    (req_op),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .o_grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        req_data[id*32 +: 32] = d;
        req_shamt[id*5 +: 5]  = s;
        req_op[id*2 +: 2]     = op;
    endtask

    task automatic note_grant(input int id);
`ifdef SHIFT_ARB_PERF_EN
        if (exp_cnt[id] < 3) exp_cnt[id]++;
`endif
    endtask

    task automatic check_rsp(input string name, input logic [31:0] d, input int id);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_data"}, rsp_data, d);
        check({name, "_id"}, 32'(rsp_id), 32'(id));
    endtask

    initial begin
        vecs[0] = '{0, 32'h8000_0001, 5'd4,  2'b10, 32'hF800_0000};
        vecs[1] = '{1, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001};
        vecs[2] = '{0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
        vecs[3] = '{1, 32'h1234_5678, 5'd7,  2'b11, 32'h1234_5678};
        vecs[4] = '{0, 32'h8000_0000, 5'd0,  2'b10, 32'h8000_0000};
        vecs[5] = '{1, 32'h8765_4321, 5'd8,  2'b01, 32'h0087_6543};
        vecs[6] = '{0, 32'h8765_4321, 5'd8,  2'b10, 32'hFF87_6543};
        vecs[7] = '{1, 32'h0000_00F0, 5'd4,  2'b00, 32'h0000_0F00};
        vecs[8] = '{0, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
        vecs[9] = '{1, 32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};

        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shamt = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_cnt", 32'(grant_cnt), 32'd0);
        rst = 1'b0;

        // Single-requester vectors, back-to-back with rsp_ready=1
        for (int v = 0; v < 10; v++) begin
            req_valid = '0;
            set_req(vecs[v].id, vecs[v].data, vecs[v].shamt, vecs[v].op);
            req_valid[vecs[v].id] = 1'b1;
            #1;
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(2'b01 << vecs[v].id));
            note_grant(vecs[v].id);
            @(negedge clk);
            check_rsp($sformatf("vec%0d", v), vecs[v].exp, vecs[v].id);
        end

        // Contention: both valid, grants alternate starting at 0
        set_req(0, 32'h1, 5'd1, 2'b00);
        set_req(1, 32'h1, 5'd1, 2'b00);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont%0d_ready", i), 32'(req_ready), 32'(2'b01 << (i % 2)));
            note_grant(i % 2);
            @(negedge clk);
            check_rsp($sformatf("cont%0d", i), 32'h2, i % 2);
        end

        // Backpressure: slot holds id1/0x2 while req1 waits
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        set_req(1, 32'hA5A5_0000, 5'd16, 2'b01);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            @(negedge clk);
            check_rsp($sformatf("bp%0d_hold", i), 32'h2, 1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'(2'b10));
        note_grant(1);
        @(negedge clk);
        check_rsp("bp_release", 32'h0000_A5A5, 1);
        req_valid = '0;
        #1;
        check("drain_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("drain_valid", 32'(rsp_valid), 32'd0);

        // Reset mid-operation with a pending, stalled response and rr_ptr != 0
        rsp_ready = 1'b0;
        set_req(0, 32'h0000_1234, 5'd3, 2'b11);
        req_valid = 2'b01;
        note_grant(0);
        @(negedge clk);
        check_rsp("pre_rst", 32'h0000_1234, 0);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_data", rsp_data, 32'd0);
        check("midrst_cnt", 32'(grant_cnt), 32'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 32'h0000_0003, 5'd2, 2'b00);
        set_req(1, 32'h0000_0040, 5'd2, 2'b01);
        req_valid = 2'b11;
        #1;
        check("postrst_ready", 32'(req_ready), 32'(2'b01));
        note_grant(0);
        @(negedge clk);
        check_rsp("postrst", 32'h0000_000C, 0);

        // Five consecutive grants to req1 then counter check
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("sat%0d_ready", i), 32'(req_ready), 32'(2'b10));
            note_grant(1);
            @(negedge clk);
            check_rsp($sformatf("sat%0d", i), 32'h0000_0010, 1);
        end
        req_valid = '0;
        check("cnt0", 32'(grant_cnt[0*CNT_W +: CNT_W]), 32'(exp_cnt[0]));
        check("cnt1", 32'(grant_cnt[1*CNT_W +: CNT_W]), 32'(exp_cnt[1]));
        @(negedge clk);
        check("final_valid", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
